// File: rtl/ifu_pkg.sv
// Shared CPU constants and the instruction-buffer entry type used by the fetch unit.
package ifu_pkg;

    localparam logic [31:0] RESET_PC        = 32'h0000_3000;
    localparam int          IBUF_DEPTH      = 2;
    localparam int          MAX_OUTSTANDING = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ibuf_entry_t;

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus: redirect from next-PC, imem request/response, decode-side instruction handshake.
interface ifu_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
    );

endinterface

// File: rtl/ifu_buf.sv
// In-order {pc, instr} FIFO between imem responses and decode; flush wins over push/pop.
module ifu_buf
    import ifu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_flush,
    input  logic        i_push,
    input  ibuf_entry_t i_push_data,
    input  logic        i_pop,
    output logic [1:0]  o_count,
    output ibuf_entry_t o_head
);

    localparam int PTR_W = $clog2(IBUF_DEPTH);

    ibuf_entry_t        r_mem [IBUF_DEPTH];
    logic [PTR_W-1:0]   r_wp;
    logic [PTR_W-1:0]   r_rp;
    logic [1:0]         r_count;
    logic               w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rp];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= 2'd0;
            for (int i = 0; i < IBUF_DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_push_data;
                r_wp        <= r_wp + PTR_W'(1);
            end
            if (w_pop) r_rp <= r_rp + PTR_W'(1);
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: issues word fetches, tags in-order responses with their PC,
// buffers two instructions for decode and squashes stale fetches on a redirect.
module ifu
    import ifu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    ifu_if.master bus
);

    localparam int TAG_W = $clog2(MAX_OUTSTANDING);

    logic [31:0]      r_pc;
    logic [1:0]       r_out;
    logic [1:0]       r_disc;
    logic [31:0]      r_ipc [MAX_OUTSTANDING];
    logic [TAG_W-1:0] r_iwp;
    logic [TAG_W-1:0] r_irp;

    logic             w_accept;
    logic             w_rsp;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count;
    logic [31:0]      w_target;
    ibuf_entry_t      w_head;
    ibuf_entry_t      w_push_data;

    // Outstanding fetches reserve buffer slots, so a response always has room.
    assign bus.imem_req_valid = reset && !bus.redirect_valid &&
                                (({1'b0, r_out} + {1'b0, w_count}) < 3'(IBUF_DEPTH));
    assign bus.imem_req_addr  = r_pc;

    assign w_accept = bus.imem_req_valid && bus.imem_req_ready;
    assign w_rsp    = bus.imem_rsp_valid && (r_out != 2'd0);
    assign w_push   = w_rsp && (r_disc == 2'd0) && !bus.redirect_valid;
    assign w_pop    = bus.instr_valid && bus.instr_ready;
    assign w_target = bus.redirect_pc & 32'hFFFF_FFFC;

    assign w_push_data.pc    = r_ipc[r_irp];
    assign w_push_data.instr = bus.imem_rsp_data;

    assign bus.instr_valid = (w_count != 2'd0);
    assign bus.instr       = w_head.instr;
    assign bus.instr_pc    = w_head.pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= RESET_PC;
            r_out  <= 2'd0;
            r_disc <= 2'd0;
            r_iwp  <= '0;
            r_irp  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) r_ipc[i] <= '0;
        end else begin
            if (bus.redirect_valid) r_pc <= w_target;
            else if (w_accept)      r_pc <= r_pc + 32'd4;

            r_out <= r_out + {1'b0, w_accept} - {1'b0, w_rsp};

            // Everything still in flight after this cycle belongs to the old path.
            if (bus.redirect_valid)              r_disc <= r_out - {1'b0, w_rsp};
            else if (w_rsp && r_disc != 2'd0)    r_disc <= r_disc - 2'd1;

            if (w_accept) begin
                r_ipc[r_iwp] <= r_pc;
                r_iwp        <= r_iwp + TAG_W'(1);
            end
            if (w_rsp) r_irp <= r_irp + TAG_W'(1);
        end
    end

    ifu_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (bus.redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: memory model with queued in-order responses and a delivery scoreboard.
module tb_ifu;
    import ifu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifu_if bus ();

    ifu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          n_deliv = 0;
    int          d0;
    ibuf_entry_t exp_q [$];
    logic [31:0] rq [$];
    logic [31:0] exp_fpc;
    bit          mem_hold;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive memory response, score outputs, advance to next negedge.
    task automatic step();
        ibuf_entry_t e;
        logic [31:0] a;
        if (!mem_hold && rq.size() > 0) begin
            a = rq.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(a);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        if (bus.instr_valid && bus.instr_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("instr_pc", bus.instr_pc, e.pc);
                chk("instr", bus.instr, e.instr);
                n_deliv++;
            end
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_req_addr, exp_fpc);
            e.pc    = exp_fpc;
            e.instr = mem_word(exp_fpc);
            exp_q.push_back(e);
            rq.push_back(bus.imem_req_addr);
            exp_fpc = exp_fpc + 32'd4;
        end
        if (bus.redirect_valid) begin
            chk("req_blocked", 32'(bus.imem_req_valid), 32'd0);
            exp_q.delete();
            exp_fpc = bus.redirect_pc & 32'hFFFF_FFFC;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b1;
        mem_hold           = 1'b0;
        exp_fpc            = RESET_PC;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0000_3000);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);

        // Reset release, 1-cycle memory, decode always ready
        reset = 1'b1;
        #1;
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        step();
        chk("lat_c1_valid", 32'(bus.instr_valid), 32'd0);
        step();
        chk("lat_c2_valid", 32'(bus.instr_valid), 32'd1);
        chk("lat_c2_pc", bus.instr_pc, 32'h0000_3000);
        step();
        chk("b2b_valid", 32'(bus.instr_valid), 32'd1);
        chk("b2b_pc", bus.instr_pc, 32'h0000_3004);
        repeat (6) step();

        // Decode backpressure
        bus.instr_ready = 1'b0;
        repeat (5) step();
        chk("bp_count", 32'(dut.w_count), 32'd2);
        chk("bp_out", 32'(dut.r_out), 32'd0);
        chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
        bus.instr_ready = 1'b1;
        d0 = n_deliv;
        repeat (6) step();
        chk("bp_release_deliv", 32'(n_deliv - d0 >= 2), 32'd1);

        // Redirect with two fetches in flight
        mem_hold = 1'b1;
        repeat (4) step();
        chk("rd_out", 32'(dut.r_out), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_3100;
        step();
        bus.redirect_valid = 1'b0;
        chk("rd_disc", 32'(dut.r_disc), 32'd2);
        chk("rd_addr", bus.imem_req_addr, 32'h0000_3100);
        mem_hold = 1'b0;
        d0 = n_deliv;
        repeat (10) step();
        chk("rd_deliv", 32'(n_deliv > d0), 32'd1);

        // Unaligned redirect target
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_3102;
        step();
        bus.redirect_valid = 1'b0;
        chk("align_addr", bus.imem_req_addr, 32'h0000_3100);
        repeat (6) step();

        // Fetch PC wraps through zero
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        step();
        bus.redirect_valid = 1'b0;
        d0 = n_deliv;
        repeat (12) step();
        chk("wrap_deliv", 32'(n_deliv - d0 >= 4), 32'd1);

        // Redirect, head handshake and response in the same cycle
        bus.instr_ready = 1'b0;
        repeat (6) step();
        chk("coll_fill", 32'(dut.w_count), 32'd2);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        step();
        chk("coll_pre_valid", 32'(bus.instr_valid), 32'd1);
        chk("coll_pre_out", 32'(dut.r_out), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_3400;
        bus.instr_ready    = 1'b1;
        d0 = n_deliv;
        step();
        bus.redirect_valid = 1'b0;
        chk("coll_deliv_once", 32'(n_deliv), 32'(d0 + 1));
        chk("coll_disc", 32'(dut.r_disc), 32'd0);
        chk("coll_out", 32'(dut.r_out), 32'd0);
        chk("coll_flushed", 32'(bus.instr_valid), 32'd0);

        // Reset asserted with one fetch in flight
        mem_hold = 1'b1;
        step();
        chk("mid_out", 32'(dut.r_out), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("mid_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("mid_instr", bus.instr, 32'h0);
        chk("mid_instr_pc", bus.instr_pc, 32'h0);
        chk("mid_req_addr", bus.imem_req_addr, 32'h0000_3000);
        exp_q.delete();
        exp_fpc = RESET_PC;
        repeat (2) @(negedge clk);
        reset              = 1'b1;
        bus.imem_req_ready = 1'b0;
        mem_hold           = 1'b0;
        step();
        step();
        step();
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("stall_req_addr", bus.imem_req_addr, 32'h0000_3000);
        chk("stray_out", 32'(dut.r_out), 32'd0);
        chk("stray_instr_valid", 32'(bus.instr_valid), 32'd0);
        bus.imem_req_ready = 1'b1;
        d0 = n_deliv;
        repeat (8) step();
        chk("restart_deliv", 32'(n_deliv - d0 >= 2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
